// File: rtl/mdu_div_issue.sv
// Issue/retire controller for the multi-cycle integer divider: screens trivial
// cases, holds operands stable while the divider works, and hands back the result.
module mdu_div_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic [2:0]  div_sel,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_ready,
    input  logic [31:0] div_res,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for an op
    // ISSUE  | divider driven, waiting for div_ready
    // HOLD   | result captured, waiting for div_ready to drop
    // RESULT | out_valid asserted until out_ready
    // ABORT  | flushed while issued, waiting for div_ready to drop
    typedef enum logic [2:0] {IDLE, ISSUE, HOLD, RESULT, ABORT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  f3_q;
    logic [31:0] a_q, b_q;
    logic        discard_q;
    logic        rst_wait_q;
    logic        accept;
    logic        ovf, fast;
    logic [31:0] fast_val;

    // The divider may still be holding ready from a pre-reset launch.
    assign in_ready  = (state == IDLE) & ~flush & ~rst_wait_q;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != IDLE);
    assign out_valid = (state == RESULT) & ~flush;

    assign ovf  = ~in_funct3[0] & (in_rs1 == 32'h8000_0000) & (in_rs2 == 32'hFFFF_FFFF);
    assign fast = ~in_funct3[2] | (in_rs2 == 32'd0) | ovf;

    always_comb begin
        fast_val = 32'd0;
        if (!in_funct3[2])
            fast_val = 32'd0;
        else if (in_rs2 == 32'd0)
            fast_val = in_funct3[1] ? in_rs1 : 32'hFFFF_FFFF;
        else if (ovf)
            fast_val = in_funct3[1] ? 32'd0 : 32'h8000_0000;
    end

    always_comb begin
        div_sel = 3'b000;
        div_a   = 32'd0;
        div_b   = 32'd0;
        if (state == ISSUE) begin
            div_sel = {1'b0, f3_q[1:0]} + 3'd1;
            div_a   = a_q;
            div_b   = b_q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = fast ? RESULT : ISSUE;
            ISSUE:   if (flush) state_nxt = ABORT;
                     else if (div_ready) state_nxt = HOLD;
            HOLD:    if (!div_ready) state_nxt = (discard_q | flush) ? IDLE : RESULT;
            RESULT:  if (flush || out_ready) state_nxt = IDLE;
            ABORT:   if (!div_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f3_q       <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            out_rd     <= 5'd0;
            out_data   <= 32'd0;
            discard_q  <= 1'b0;
            rst_wait_q <= 1'b1;
        end else begin
            if (!div_ready)
                rst_wait_q <= 1'b0;
            if (accept) begin
                f3_q      <= in_funct3;
                a_q       <= in_rs1;
                b_q       <= in_rs2;
                out_rd    <= in_rd;
                discard_q <= 1'b0;
                if (fast)
                    out_data <= fast_val;
            end
            if (state == ISSUE && !flush && div_ready)
                out_data <= div_res;
            if (state == HOLD && flush)
                discard_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mdu_div_issue.sv
// Directed bench for mdu_div_issue with a behavioural multi-cycle divider
// whose ready stays high for a few cycles after the select drops.
module tb_mdu_div_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_rs1 = 32'd0;
    logic [31:0] in_rs2 = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic [2:0]  div_sel;
    logic [31:0] div_a, div_b;
    logic        div_ready;
    logic [31:0] div_res;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_div_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .div_sel(div_sel), .div_a(div_a), .div_b(div_b),
        .div_ready(div_ready), .div_res(div_res), .busy(busy)
    );

    // behavioural divider: launches on non-zero select, result after LAT cycles
    localparam int LAT = 12;
    int          dcnt = 0;
    logic        dready_q = 1'b0;
    logic [31:0] dres_q = 32'd0;
    int          dhold = 0;
    logic        force_ready = 1'b0;
    logic [31:0] calc;

    always_comb begin
        calc = 32'd0;
        case (div_sel)
            3'd1: calc = $signed(div_a) / $signed(div_b);
            3'd2: calc = div_a / div_b;
            3'd3: calc = $signed(div_a) % $signed(div_b);
            3'd4: calc = div_a % div_b;
            default: calc = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (dready_q) begin
            if (div_sel == 3'd0) begin
                if (dhold == 0) begin dready_q <= 1'b0; dcnt <= 0; end
                else dhold <= dhold - 1;
            end
        end else if (div_sel != 3'd0) begin
            if (dcnt == LAT) begin dready_q <= 1'b1; dres_q <= calc; dhold <= 2; end
            else dcnt <= dcnt + 1;
        end else begin
            dcnt <= 0;
        end
    end

    assign div_ready = dready_q | force_ready;
    assign div_res   = dres_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic offer(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
    endtask

    // code = expected div_sel while issued (0 for the fast path)
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input logic [2:0] code, input int stall);
        int lat;
        int rdy_sel;
        logic [2:0] sel_max;
        out_ready = (stall == 0);
        offer(f3, a, b, rd);
        lat = 0;
        while (!in_ready && lat < 20) begin @(negedge clk); lat++; end
        chk({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1; rdy_sel = 0; sel_max = 3'd0;
        while (!out_valid && lat < 40) begin
            if (div_sel > sel_max) sel_max = div_sel;
            if (div_ready && div_sel != 3'd0) rdy_sel++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, out_data, exp);
        chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        chk({tag, "_sel"}, {29'd0, sel_max}, {29'd0, code});
        chk({tag, "_selhold"}, rdy_sel, (code != 3'd0) ? 32'd1 : 32'd0);
        if (code == 3'd0) chk({tag, "_lat"}, lat, 32'd1);
        for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall_v"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_stall_d"}, out_data, exp);
            chk({tag, "_stall_rdy"}, {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_onecyc"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        logic seen;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sel", {29'd0, div_sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", out_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", {31'd0, in_ready}, 32'd1);

        run_op("divu100_7", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14, 3'd2, 0);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 3'd3, 0);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 3'd1, 0);
        run_op("div5_0", 3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 3'd0, 0);
        run_op("remu5_0", 3'b111, 32'd5, 32'd0, 5'd9, 32'd5, 3'd0, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 3'd0, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 3'd0, 0);
        run_op("mul_op", 3'b000, 32'd3, 32'd4, 5'd12, 32'd0, 3'd0, 0);

        // flush 10 cycles into an issued DIVU
        offer(3'b101, 32'd1000, 32'd3, 5'd13);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_sel", {29'd0, div_sel}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_noval", {31'd0, seen}, 32'd0);
        chk("flush_idle", {31'd0, busy}, 32'd0);
        run_op("divu9_3", 3'b101, 32'd9, 32'd3, 5'd14, 32'd3, 3'd2, 0);

        // flush while HOLD waits for ready to drop
        offer(3'b101, 32'd50, 32'd5, 5'd15);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!div_ready && n < 40) begin @(negedge clk); n++; end
        chk("hold_rdy", {31'd0, div_ready}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        chk("hold_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("hold_noval", {31'd0, seen}, 32'd0);
        chk("hold_idle", {31'd0, busy}, 32'd0);

        run_op("stall5", 3'b101, 32'd20, 32'd4, 5'd9, 32'd5, 3'd2, 5);

        // flush in RESULT beats a simultaneous out_ready
        out_ready = 1'b0;
        offer(3'b100, 32'd7, 32'd0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("rflush_pre", {31'd0, out_valid}, 32'd1);
        flush = 1'b1; out_ready = 1'b1;
        #1;
        chk("rflush_drop", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("rflush_idle", {31'd0, busy}, 32'd0);
        chk("rflush_noval", {31'd0, out_valid}, 32'd0);

        // flush in IDLE blocks acceptance
        flush = 1'b1;
        #1;
        chk("iflush_rdy", {31'd0, in_ready}, 32'd0);
        flush = 1'b0;

        // asynchronous reset while issued
        @(negedge clk);
        offer(3'b101, 32'd77, 32'd7, 5'd21);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_sel", {29'd0, div_sel}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", {29'd0, div_sel}, 32'd0);
        chk("arst_a", div_a, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_data", out_data, 32'd0);
        chk("arst_rd", {27'd0, out_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("remu10_4", 3'b111, 32'd10, 32'd4, 5'd2, 32'd2, 3'd4, 0);

        // first accept after reset waits for divider ready to fall
        force_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        offer(3'b111, 32'd10, 32'd4, 5'd4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rwait_rdy", {31'd0, in_ready}, 32'd0);
        end
        force_ready = 1'b0;
        run_op("rwait_op", 3'b111, 32'd10, 32'd4, 5'd4, 32'd2, 3'd4, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
